// File: rtl/spu_calc_arbiter_if.sv
// Request, element and result bus of the shared calc arbiter.
// slave is the arbiter's view; master is the environment's view.
interface spu_calc_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int CALC_LATENCY = 3,
  parameter int ID_BITS      = $clog2(NUM_REQ),
  parameter int OUT_BITS     = $clog2(CALC_LATENCY+1)+1
);
  logic [NUM_REQ*DATA_BITS-1:0] s_data0;
  logic [NUM_REQ*DATA_BITS-1:0] s_data1;
  logic [NUM_REQ-1:0]           s_valid;
  logic [NUM_REQ-1:0]           s_ready;
  logic [DATA_BITS-1:0]         e_data0;
  logic [DATA_BITS-1:0]         e_data1;
  logic                         e_valid;
  logic                         e_cke;
  logic [DATA_BITS-1:0]         e_res0;
  logic [DATA_BITS-1:0]         e_res1;
  logic                         e_res_valid;
  logic [DATA_BITS-1:0]         m_data0;
  logic [DATA_BITS-1:0]         m_data1;
  logic [ID_BITS-1:0]           m_id;
  logic                         m_valid;
  logic                         m_ready;
  logic [OUT_BITS-1:0]          outstanding;
  logic                         err_sync;

  modport slave (
    input  s_data0, s_data1, s_valid,
    output s_ready,
    output e_data0, e_data1, e_valid, e_cke,
    input  e_res0, e_res1, e_res_valid,
    output m_data0, m_data1, m_id, m_valid,
    input  m_ready,
    output outstanding, err_sync
  );

  modport master (
    output s_data0, s_data1, s_valid,
    input  s_ready,
    input  e_data0, e_data1, e_valid, e_cke,
    output e_res0, e_res1, e_res_valid,
    input  m_data0, m_data1, m_id, m_valid,
    output m_ready,
    input  outstanding, err_sync
  );
endinterface

// File: rtl/spu_calc_arbiter.sv
// Round-robin arbiter feeding a fixed-latency shared calc element.
// A tag pipe tracks result ownership; a stalled result freezes everything.
module spu_calc_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int CALC_LATENCY = 3,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  spu_calc_arbiter_if.slave       bus
);

  localparam int OUT_BITS = $clog2(CALC_LATENCY+1)+1;

  typedef struct packed {
    logic               valid;
    logic [ID_BITS-1:0] id;
  } tag_t;

  tag_t               tag_q [CALC_LATENCY];
  tag_t               tag_last;
  logic [ID_BITS-1:0] last_grant;
  logic [ID_BITS-1:0] grant;
  logic               gnt_vld;
  logic               cke;
  logic               xfer;
  logic               done;
  logic [NUM_REQ-1:0] ready;
  logic [OUT_BITS-1:0] outst_q;
  logic               err_q;

  assign tag_last = tag_q[CALC_LATENCY-1];
  assign cke      = !(tag_last.valid && !bus.m_ready);
  assign done     = tag_last.valid && bus.m_ready;

  // first asserted requester after the previous winner
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!gnt_vld && bus.s_valid[idx]) begin
        gnt_vld = 1'b1;
        grant   = ID_BITS'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (reset_n && gnt_vld && cke)
      ready[grant] = 1'b1;
  end

  assign xfer        = |(bus.s_valid & ready);
  assign bus.s_ready = ready;
  assign bus.e_valid = xfer;
  assign bus.e_cke   = cke;
  assign bus.e_data0 = bus.s_data0[int'(grant)*DATA_BITS +: DATA_BITS];
  assign bus.e_data1 = bus.s_data1[int'(grant)*DATA_BITS +: DATA_BITS];

  assign bus.m_valid     = tag_last.valid;
  assign bus.m_id        = tag_last.id;
  assign bus.m_data0     = bus.e_res0;
  assign bus.m_data1     = bus.e_res1;
  assign bus.outstanding = outst_q;
  assign bus.err_sync    = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CALC_LATENCY; i++)
        tag_q[i] <= '0;
    end else if (cke) begin
      tag_q[0] <= '{valid: xfer, id: grant};
      for (int i = 1; i < CALC_LATENCY; i++)
        tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      last_grant <= ID_BITS'(NUM_REQ-1);
    else if (xfer)
      last_grant <= grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      outst_q <= '0;
    else if (xfer && !done)
      outst_q <= outst_q + 1'b1;
    else if (done && !xfer)
      outst_q <= outst_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (cke && (tag_last.valid != bus.e_res_valid))
      err_q <= 1'b1;
  end

endmodule

// File: doc/spu_calc_arbiter.md
SPU_CALC_ARBITER -- requirements
Module: spu_calc_arbiter

Interface
REQ-001 The block SHALL take these parameters:
- NUM_REQ, default 4: requester count, 2..8.
- DATA_BITS, default 8: operand and result width, signed.
- CALC_LATENCY, default 3: fixed pipeline depth of the shared calc element, in cke-enabled cycles.
- ID_BITS, default clog2(NUM_REQ): requester ID width.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- s_data0  in  NUM_REQ*DATA_BITS  operand 0, per requester, requester i in slice i.
- s_data1  in  NUM_REQ*DATA_BITS  operand 1, per requester.
- s_valid  in  NUM_REQ  request valid, per requester.
- s_ready  out  NUM_REQ  request accepted, per requester.
- e_data0 / e_data1  out  DATA_BITS each  operands to the calc element.
- e_valid  out  1  operand valid to the element.
- e_cke  out  1  element clock enable.
- e_res0 / e_res1  in  DATA_BITS each  element product / sum results.
- e_res_valid  in  1  element output valid.
- m_data0 / m_data1  out  DATA_BITS each  result (product / sum).
- m_id  out  ID_BITS  requester ID that owns the result.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- outstanding  out  clog2(CALC_LATENCY+1)+1  count of issued, uncompleted operations.
- err_sync  out  1  sticky tag/element valid mismatch flag.

Function
REQ-003 The block SHALL drive e_cke = NOT(m_valid AND NOT m_ready); all internal pipeline state SHALL advance only when e_cke=1.
REQ-004 Arbitration SHALL be round-robin over s_valid, starting at (last_grant+1) mod NUM_REQ and taking the first asserted requester; it SHALL be combinational from s_valid and the registered last_grant.
REQ-005 s_ready[i] SHALL equal (grant==i AND e_cke); at most one s_ready bit SHALL be high in any cycle.
REQ-006 A transfer SHALL occur when s_valid[i] AND s_ready[i]; on a transfer, last_grant SHALL update to i; with no transfer, last_grant SHALL hold.
REQ-007 e_data0/e_data1 SHALL mux the granted requester's operands; e_valid SHALL be 1 only in transfer cycles.
REQ-008 Operands SHALL be passed unmodified; the element computes the low DATA_BITS of s_data0*s_data1 and of s_data0+s_data1, both wrapping.
REQ-009 A tag pipeline of CALC_LATENCY stages {valid, id} SHALL shift on e_cke=1; stage 0 SHALL load {e_valid, grant}.
REQ-010 m_valid and m_id SHALL come from the last tag stage; m_data0/m_data1 SHALL pass e_res0/e_res1 combinationally.
REQ-011 Latency from a transfer to m_valid SHALL be exactly CALC_LATENCY cycles when no stall occurs; each stall cycle SHALL add one cycle.
REQ-012 While m_valid=1 and m_ready=0, the following SHALL hold stable: m_data0, m_data1, m_id, m_valid, and the whole pipeline.
REQ-013 outstanding SHALL increment on a transfer and decrement on (m_valid AND m_ready); it SHALL be unchanged when both occur in the same cycle.
REQ-014 On any cycle where e_cke=1 and the last tag valid differs from e_res_valid, err_sync SHALL set and stay set until reset.
REQ-015 Simultaneous requests from all NUM_REQ requesters held continuously SHALL be granted in strict rotation, each once per NUM_REQ transfers.
REQ-016 A requester dropping s_valid before its transfer is legal; arbitration SHALL re-evaluate in the same cycle.

Reset
REQ-017 While reset_n=0 the following SHALL hold asynchronously: all tag valids=0, m_valid=0, s_ready=0, e_valid=0, outstanding=0, err_sync=0, last_grant=NUM_REQ-1, m_id=0.
REQ-018 Reset deassertion SHALL be synchronized by the integrator; the first arbitration after reset SHALL favour requester 0.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight tags; no result for pre-reset transfers SHALL appear after release.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single request, idle pipe: requester 2 sends data0=3, data1=-5 with m_ready=1 -> 3 cycles later m_valid=1, m_id=2, m_data0=-15 (0xF1), m_data1=-2.
- Full contention: all 4 requesters valid for 8 cycles, m_ready=1 -> grant order 0,1,2,3,0,1,2,3; m_id follows the same order 3 cycles later.
- Backpressure: m_ready=0 for 5 cycles while a result is valid -> e_cke=0, s_ready=0, outputs stable, outstanding frozen; no result lost or duplicated after release.
- Wrap: data0=127, data1=127 -> m_data0=0x01, m_data1=0xFE (-2).
- Reset mid-flight: 2 transfers issued, then reset_n pulsed low -> m_valid=0 and outstanding=0 immediately; no stale results after release.
- Mismatch injection: force e_res_valid=1 with an empty tag pipe -> err_sync=1 and stays 1 until reset.
